// File: rtl/dmem_load_ctrl.sv
// dmem_load_ctrl: MEM-stage load controller driving the SRAM word read controller,
// with sub-word extraction and a one-entry last-word buffer.
module dmem_load_ctrl #(
    parameter int ADDR_W = 20,
    parameter bit BUF_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic [31:0]       mem_addr,
    input  logic [2:0]        mem_op,
    input  logic              inv,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              addr_err,
    output logic              read_ce,
    output logic [ADDR_W-1:0] address,
    input  logic [31:0]       rd_data,
    input  logic              rfin
);
    typedef enum logic [1:0] {IDLE, RD, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] buf_addr;
    logic [31:0]       buf_word;
    logic              buf_valid;
    logic              inv_seen;
    logic [2:0]        op_r;
    logic [1:0]        lane_r;
    logic [ADDR_W-1:0] word_addr;
    logic              misaligned;
    logic              hit;
    logic              unused_ok;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] op, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lane +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        return op == 3'b000 ? {{24{b[7]}}, b} :
               op == 3'b100 ? {24'b0, b} :
               op == 3'b001 ? {{16{h[15]}}, h} :
               op == 3'b101 ? {16'b0, h} : w;
    endfunction

    assign word_addr  = mem_addr[ADDR_W+1:2];
    // op[1] set means word access (LW and all undefined encodings); op[1:0]==01 is a halfword
    assign misaligned = mem_op[1] ? |mem_addr[1:0] : (mem_op[0] & mem_addr[0]);
    assign hit        = BUF_EN && buf_valid && !inv && buf_addr == word_addr;
    assign stall      = mem_req & ~load_valid;
    assign unused_ok  = &{1'b0, mem_addr[31:ADDR_W+2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            read_ce    <= 1'b0;
            address    <= '0;
            load_valid <= 1'b0;
            load_data  <= '0;
            addr_err   <= 1'b0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_word   <= '0;
            inv_seen   <= 1'b0;
            op_r       <= '0;
            lane_r     <= '0;
        end else begin
            load_valid <= 1'b0;
            if (inv)
                buf_valid <= 1'b0;
            case (state)
                IDLE: if (mem_req) begin
                    addr_err <= misaligned;
                    if (misaligned) begin
                        load_data  <= '0;
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else if (hit) begin
                        load_data  <= extract(buf_word, mem_op, mem_addr[1:0]);
                        load_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        read_ce  <= 1'b1;
                        address  <= word_addr;
                        op_r     <= mem_op;
                        lane_r   <= mem_addr[1:0];
                        inv_seen <= 1'b0;
                        state    <= RD;
                    end
                end
                RD: begin
                    if (inv)
                        inv_seen <= 1'b1;
                    // a store seen at any point of the read makes the returned word stale for reuse
                    if (rfin) begin
                        read_ce    <= 1'b0;
                        load_data  <= extract(rd_data, op_r, lane_r);
                        load_valid <= 1'b1;
                        buf_addr   <= address;
                        buf_word   <= rd_data;
                        buf_valid  <= BUF_EN && !inv && !inv_seen;
                        state      <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_load_ctrl.sv
// tb_dmem_load_ctrl: scoreboard bench with a behavioural SRAM read-controller model.
module tb_dmem_load_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [2:0]  mem_op;
    logic        inv_t;
    logic        inv_s;
    logic        inv;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        addr_err;
    logic        read_ce;
    logic [19:0] address;
    logic [31:0] rd_data;
    logic        rfin;

    logic [31:0] mem [0:31];
    logic [32:0] sb [$];
    int          errors = 0;
    int          checks = 0;
    int          reads = 0;
    int          ce_bad = 0;
    int          cnt = 0;
    logic [19:0] last_addr = '0;
    logic        inv_on_rfin = 1'b0;

    assign inv = inv_t | inv_s;

    dmem_load_ctrl #(.ADDR_W(20), .BUF_EN(1)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_op(mem_op),
        .inv(inv), .stall(stall), .load_valid(load_valid), .load_data(load_data),
        .addr_err(addr_err), .read_ce(read_ce), .address(address), .rd_data(rd_data), .rfin(rfin)
    );

    always #5 clk = ~clk;

    // read controller model: rfin two cycles after read_ce rises, one-cycle pulse
    initial begin
        rfin = 1'b0;
        rd_data = '0;
        inv_s = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rfin && read_ce)
                ce_bad++;
            if (rfin) begin
                rfin = 1'b0;
                inv_s = 1'b0;
                cnt = 0;
            end else if (read_ce) begin
                cnt++;
                if (cnt >= 2) begin
                    rfin = 1'b1;
                    rd_data = mem[address[4:0]];
                    last_addr = address;
                    reads++;
                    inv_s = inv_on_rfin;
                end
            end else
                cnt = 0;
        end
    end

    task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] op,
                           input logic [31:0] d, input logic e, input int exp_reads);
        int r0;
        int lat;
        bit got;
        logic [32:0] ex;
        r0 = reads;
        sb.push_back({e, d});
        mem_req = 1'b1;
        mem_addr = a;
        mem_op = op;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (load_valid)
                got = 1;
            else begin
                checks++;
                if (stall !== 1'b1) begin
                    errors++;
                    $display("FAIL %s stall: got %b expected 1", nm, stall);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no load_valid within %0d cycles", nm, lat);
            void'(sb.pop_front());
        end else begin
            ex = sb.pop_front();
            checks += 5;
            if (load_data !== ex[31:0]) begin
                errors++;
                $display("FAIL %s data: got %h expected %h", nm, load_data, ex[31:0]);
            end
            if (addr_err !== ex[32]) begin
                errors++;
                $display("FAIL %s addr_err: got %b expected %b", nm, addr_err, ex[32]);
            end
            if (reads - r0 !== exp_reads) begin
                errors++;
                $display("FAIL %s reads: got %0d expected %0d", nm, reads - r0, exp_reads);
            end
            if (exp_reads == 0 ? lat != 1 : lat < 2) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %s", nm, lat, exp_reads == 0 ? "1" : ">1");
            end
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL %s stall_at_valid: got %b expected 0", nm, stall);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (load_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: load_valid got %b expected 0", nm, load_valid);
        end
        mem_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (read_ce !== 1'b0) begin errors++; $display("FAIL rst read_ce: got %b expected 0", read_ce); end
        if (address !== 20'h0) begin errors++; $display("FAIL rst address: got %h expected 0", address); end
        if (load_valid !== 1'b0) begin errors++; $display("FAIL rst load_valid: got %b expected 0", load_valid); end
        if (load_data !== 32'h0) begin errors++; $display("FAIL rst load_data: got %h expected 0", load_data); end
        if (addr_err !== 1'b0) begin errors++; $display("FAIL rst addr_err: got %b expected 0", addr_err); end
        if (stall !== 1'b0) begin errors++; $display("FAIL rst stall: got %b expected 0", stall); end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        do_load("lw_miss", 32'h10, 3'b010, 32'h8899_AABB, 1'b0, 1);
        checks++;
        if (last_addr !== 20'h00004) begin
            errors++;
            $display("FAIL lw_addr: got %h expected 00004", last_addr);
        end
    endtask

    task automatic test_hits();
        do_load("lb_hit", 32'h13, 3'b000, 32'hFFFF_FF88, 1'b0, 0);
        do_load("lbu_hit", 32'h13, 3'b100, 32'h0000_0088, 1'b0, 0);
        do_load("lb_lane1", 32'h11, 3'b000, 32'hFFFF_FFAA, 1'b0, 0);
        do_load("lbu_lane0", 32'h10, 3'b100, 32'h0000_00BB, 1'b0, 0);
        do_load("lhu_lo", 32'h10, 3'b101, 32'h0000_AABB, 1'b0, 0);
        do_load("op011_lw", 32'h10, 3'b011, 32'h8899_AABB, 1'b0, 0);
    endtask

    task automatic test_inv();
        do_load("lh_hit", 32'h12, 3'b001, 32'hFFFF_8899, 1'b0, 0);
        inv_t = 1'b1;
        @(posedge clk);
        #1;
        inv_t = 1'b0;
        do_load("lhu_after_inv", 32'h12, 3'b101, 32'h0000_8899, 1'b0, 1);
    endtask

    task automatic test_misaligned();
        do_load("lw_misal", 32'h06, 3'b010, 32'h0, 1'b1, 0);
        do_load("lh_misal", 32'h11, 3'b001, 32'h0, 1'b1, 0);
        do_load("lb_odd_ok", 32'h07, 3'b000, 32'h0000_0011, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        do_load("b2b_miss", 32'h20, 3'b010, 32'h1234_5678, 1'b0, 1);
        do_load("b2b_hit", 32'h20, 3'b010, 32'h1234_5678, 1'b0, 0);
        do_load("b2b_next", 32'h24, 3'b010, 32'h9ABC_DEF0, 1'b0, 1);
        checks++;
        if (ce_bad !== 0) begin
            errors++;
            $display("FAIL read_ce_after_rfin: got %0d cycles expected 0", ce_bad);
        end
    endtask

    task automatic test_inv_rfin();
        inv_on_rfin = 1'b1;
        do_load("inv_rfin_data", 32'h30, 3'b010, 32'hCAFE_F00D, 1'b0, 1);
        inv_on_rfin = 1'b0;
        do_load("inv_rfin_rereads", 32'h30, 3'b010, 32'hCAFE_F00D, 1'b0, 1);
        do_load("inv_rfin_then_hit", 32'h30, 3'b010, 32'hCAFE_F00D, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        mem_req = 1'b1;
        mem_addr = 32'h40;
        mem_op = 3'b010;
        @(posedge clk);
        #2;
        checks++;
        if (read_ce !== 1'b1) begin errors++; $display("FAIL rmid_ce_up: got %b expected 1", read_ce); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (read_ce !== 1'b0) begin errors++; $display("FAIL rmid_ce_drop: got %b expected 0", read_ce); end
        if (stall !== 1'b1) begin errors++; $display("FAIL rmid_stall_hi: got %b expected 1", stall); end
        mem_req = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall_lo: got %b expected 0", stall); end
        @(posedge clk);
        #1;
        checks++;
        if (load_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", load_valid); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_load("rmid_buf_cleared", 32'h30, 3'b010, 32'hCAFE_F00D, 1'b0, 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            mem[i] = 32'h0;
        mem[1] = 32'h1100_0000;
        mem[4] = 32'h8899_AABB;
        mem[8] = 32'h1234_5678;
        mem[9] = 32'h9ABC_DEF0;
        mem[12] = 32'hCAFE_F00D;
        mem[16] = 32'h5555_AAAA;
        mem_req = 1'b0;
        mem_addr = '0;
        mem_op = '0;
        inv_t = 1'b0;
        test_reset();
        test_lw();
        test_hits();
        test_inv();
        test_misaligned();
        test_back_to_back();
        test_inv_rfin();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
